// File: rtl/sdrd_dma_pkg.sv
// sdrd_dma_pkg: shared definitions for the SD sector-copy engine.
//   - config register offsets (addr[3:2]) and CTRL/STAT bit positions
//   - sequencer state encoding
//   - strobe bundle the sequencer sends to the register file
//   - address helper for the sdrd buffer window
package sdrd_dma_pkg;

  // Config register index, decoded from cfg_icb_cmd_addr[3:2]
  localparam logic [1:0] REG_SECTOR = 2'd0;
  localparam logic [1:0] REG_DST    = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // CTRL write bits
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLR_BIT   = 1;

  // STAT read bits
  localparam int STAT_BUSY_BIT     = 0;
  localparam int STAT_DONE_BIT     = 1;
  localparam int STAT_ERR_TO_BIT   = 2;
  localparam int STAT_ERR_BUS_BIT  = 3;

  // sdrd status word: busy flag position
  localparam int SD_BUSY_BIT = 24;

  localparam logic [8:0]  LAST_BYTE    = 9'd511;
  localparam logic [31:0] SECTOR_BYTES = 32'd512;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SD_WR,
    ST_POLL_CMD,
    ST_POLL_RSP,
    ST_RD_CMD,
    ST_RD_RSP,
    ST_MW_CMD,
    ST_MW_RSP,
    ST_NEXT
  } state_t;

  // One-cycle requests from the sequencer to the register file
  typedef struct packed {
    logic run;          // run accepted: set BUSY, clear DONE/ERR
    logic done;         // set DONE, clear BUSY
    logic err_timeout;  // set ERR_TIMEOUT, clear BUSY
    logic err_bus;      // set ERR_BUS, clear BUSY
    logic advance;      // SECTOR+1, DST+512, COUNT-1
  } seq_strobe_t;

  // Byte i of the sdrd buffer lives at base + 4*i
  function automatic logic [31:0] sd_byte_addr(input logic [31:0] base,
                                               input logic [8:0]  idx);
    return base + {21'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/sdrd_dma_regs.sv
// sdrd_dma_regs: config ICB slave and register file for sdrd_dma.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   cfg_icb_*            config slave (cmd/rsp handshake, addr[3:2] decoded)
//   sector, dst, count   live register values for the sequencer
//   busy, done,
//   err_timeout, err_bus status flags
//   start_pulse          START written while idle (one cycle)
//   clr_pulse            CLR written (one cycle)
//   strobe               state/counter updates requested by the sequencer
module sdrd_dma_regs
  import sdrd_dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_icb_cmd_valid,
  output logic              cfg_icb_cmd_ready,
  input  logic              cfg_icb_cmd_read,
  input  logic [31:0]       cfg_icb_cmd_addr,
  input  logic [31:0]       cfg_icb_cmd_wdata,
  input  logic [3:0]        cfg_icb_cmd_wmask,
  output logic              cfg_icb_rsp_valid,
  input  logic              cfg_icb_rsp_ready,
  output logic              cfg_icb_rsp_err,
  output logic [31:0]       cfg_icb_rsp_rdata,
  output logic [31:0]       sector,
  output logic [31:0]       dst,
  output logic [15:0]       count,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_bus,
  output logic              start_pulse,
  output logic              clr_pulse,
  input  seq_strobe_t       strobe
);

  logic [31:0] sector_reg, dst_reg;
  logic [15:0] count_reg;
  logic        busy_reg, done_reg, err_to_reg, err_bus_reg;
  logic        rsp_valid_reg;
  logic [31:0] rsp_rdata_reg, rdata_next;
  logic [1:0]  reg_idx;
  logic        cmd_hs, wr_hs, cfg_wr_ok;
  logic        unused_ok;

  assign unused_ok = ^{cfg_icb_cmd_wmask, cfg_icb_cmd_addr[31:4], cfg_icb_cmd_addr[1:0]};

  assign reg_idx           = cfg_icb_cmd_addr[3:2];
  assign cfg_icb_cmd_ready = ~rsp_valid_reg | cfg_icb_rsp_ready;
  assign cmd_hs            = cfg_icb_cmd_valid & cfg_icb_cmd_ready;
  assign wr_hs             = cmd_hs & ~cfg_icb_cmd_read;
  // Parameter registers and START are frozen while a run is in flight
  assign cfg_wr_ok         = wr_hs & ~busy_reg;

  assign start_pulse = cfg_wr_ok & (reg_idx == REG_CTRL) & cfg_icb_cmd_wdata[CTRL_START_BIT];
  assign clr_pulse   = wr_hs & (reg_idx == REG_CTRL) & cfg_icb_cmd_wdata[CTRL_CLR_BIT];

  // Parameter registers: the sequencer advance only happens while busy,
  // so it never collides with a software write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sector_reg <= '0;
      dst_reg    <= '0;
      count_reg  <= '0;
    end else if (strobe.advance) begin
      sector_reg <= sector_reg + 32'd1;
      dst_reg    <= dst_reg + SECTOR_BYTES;
      count_reg  <= count_reg - 16'd1;
    end else if (cfg_wr_ok) begin
      if (reg_idx == REG_SECTOR) sector_reg <= cfg_icb_cmd_wdata;
      if (reg_idx == REG_DST)    dst_reg    <= {cfg_icb_cmd_wdata[31:2], 2'b00};
      if (reg_idx == REG_COUNT)  count_reg  <= cfg_icb_cmd_wdata[15:0];
    end
  end

  // Status flags. CLR is applied first so a START in the same write
  // (which produces run/done strobes this cycle) takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_to_reg  <= 1'b0;
      err_bus_reg <= 1'b0;
    end else begin
      if (clr_pulse) begin
        done_reg    <= 1'b0;
        err_to_reg  <= 1'b0;
        err_bus_reg <= 1'b0;
      end
      if (strobe.run) begin
        busy_reg    <= 1'b1;
        done_reg    <= 1'b0;
        err_to_reg  <= 1'b0;
        err_bus_reg <= 1'b0;
      end
      if (strobe.done) begin
        done_reg <= 1'b1;
        busy_reg <= 1'b0;
      end
      if (strobe.err_timeout) begin
        err_to_reg <= 1'b1;
        busy_reg   <= 1'b0;
      end
      if (strobe.err_bus) begin
        err_bus_reg <= 1'b1;
        busy_reg    <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata_next = '0;
    case (reg_idx)
      REG_SECTOR: rdata_next = sector_reg;
      REG_DST:    rdata_next = dst_reg;
      REG_COUNT:  rdata_next = {16'd0, count_reg};
      default: begin
        rdata_next[STAT_BUSY_BIT]    = busy_reg;
        rdata_next[STAT_DONE_BIT]    = done_reg;
        rdata_next[STAT_ERR_TO_BIT]  = err_to_reg;
        rdata_next[STAT_ERR_BUS_BIT] = err_bus_reg;
      end
    endcase
  end

  // Every accepted command gets exactly one response the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else if (cmd_hs) begin
      rsp_valid_reg <= 1'b1;
      rsp_rdata_reg <= cfg_icb_cmd_read ? rdata_next : 32'd0;
    end else if (cfg_icb_rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign cfg_icb_rsp_valid = rsp_valid_reg;
  assign cfg_icb_rsp_rdata = rsp_rdata_reg;
  assign cfg_icb_rsp_err   = 1'b0;

  assign sector      = sector_reg;
  assign dst         = dst_reg;
  assign count       = count_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err_timeout = err_to_reg;
  assign err_bus     = err_bus_reg;

endmodule

// File: rtl/sdrd_dma.sv
// sdrd_dma: sector-copy engine from the sdrd card reader buffer to memory.
// Per sector: write SECTOR to sdrd, poll until the access completes, then
// read 512 buffer bytes, pack them little-endian and write 128 words to DST.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   cfg_icb_*       config slave (SECTOR, DST, COUNT, CTRL/STAT)
//   sd_icb_*        master to sdrd (sector write, status poll, byte reads)
//   mem_icb_*       master to system memory (word writes)
//   irq             level interrupt, DONE | ERR
module sdrd_dma
  import sdrd_dma_pkg::*;
#(
  parameter logic [23:0] POLL_TIMEOUT = 24'hFF_FFFF,
  parameter logic [31:0] SDRD_BASE    = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_icb_cmd_valid,
  output logic        cfg_icb_cmd_ready,
  input  logic        cfg_icb_cmd_read,
  input  logic [31:0] cfg_icb_cmd_addr,
  input  logic [31:0] cfg_icb_cmd_wdata,
  input  logic [3:0]  cfg_icb_cmd_wmask,
  output logic        cfg_icb_rsp_valid,
  input  logic        cfg_icb_rsp_ready,
  output logic        cfg_icb_rsp_err,
  output logic [31:0] cfg_icb_rsp_rdata,
  output logic        sd_icb_cmd_valid,
  input  logic        sd_icb_cmd_ready,
  output logic [31:0] sd_icb_cmd_addr,
  output logic        sd_icb_cmd_read,
  output logic [31:0] sd_icb_cmd_wdata,
  output logic [3:0]  sd_icb_cmd_wmask,
  input  logic        sd_icb_rsp_valid,
  output logic        sd_icb_rsp_ready,
  input  logic [31:0] sd_icb_rsp_rdata,
  output logic        mem_icb_cmd_valid,
  input  logic        mem_icb_cmd_ready,
  output logic [31:0] mem_icb_cmd_addr,
  output logic        mem_icb_cmd_read,
  output logic [31:0] mem_icb_cmd_wdata,
  output logic [3:0]  mem_icb_cmd_wmask,
  input  logic        mem_icb_rsp_valid,
  output logic        mem_icb_rsp_ready,
  input  logic        mem_icb_rsp_err,
  output logic        irq
);

  logic [31:0] sector, dst;
  logic [15:0] count;
  logic        busy, done, err_timeout, err_bus;
  logic        start_pulse, clr_pulse;
  seq_strobe_t strobe;

  state_t      state_reg, state_next;
  logic [8:0]  idx_reg;
  logic        seen_busy_reg;
  logic [23:0] poll_cnt_reg;
  logic        sector_init, idx_inc, lane_we, seen_set, in_poll;
  logic [31:0] pack_word;
  logic        sd_busy;
  logic        unused_ok;

  assign sd_busy   = sd_icb_rsp_rdata[SD_BUSY_BIT];
  assign unused_ok = ^{sd_icb_rsp_rdata[31:25], sd_icb_rsp_rdata[23:8], clr_pulse, busy};
  assign in_poll   = (state_reg == ST_POLL_CMD) || (state_reg == ST_POLL_RSP);

  sdrd_dma_regs u_regs (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_icb_cmd_valid (cfg_icb_cmd_valid),
    .cfg_icb_cmd_ready (cfg_icb_cmd_ready),
    .cfg_icb_cmd_read  (cfg_icb_cmd_read),
    .cfg_icb_cmd_addr  (cfg_icb_cmd_addr),
    .cfg_icb_cmd_wdata (cfg_icb_cmd_wdata),
    .cfg_icb_cmd_wmask (cfg_icb_cmd_wmask),
    .cfg_icb_rsp_valid (cfg_icb_rsp_valid),
    .cfg_icb_rsp_ready (cfg_icb_rsp_ready),
    .cfg_icb_rsp_err   (cfg_icb_rsp_err),
    .cfg_icb_rsp_rdata (cfg_icb_rsp_rdata),
    .sector            (sector),
    .dst               (dst),
    .count             (count),
    .busy              (busy),
    .done              (done),
    .err_timeout       (err_timeout),
    .err_bus           (err_bus),
    .start_pulse       (start_pulse),
    .clr_pulse         (clr_pulse),
    .strobe            (strobe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Byte index, poll bookkeeping. All three restart once the sector
  // number has been handed to sdrd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg       <= '0;
      seen_busy_reg <= 1'b0;
      poll_cnt_reg  <= '0;
    end else if (sector_init) begin
      idx_reg       <= '0;
      seen_busy_reg <= 1'b0;
      poll_cnt_reg  <= '0;
    end else begin
      if (idx_inc)  idx_reg <= idx_reg + 9'd1;
      if (seen_set) seen_busy_reg <= 1'b1;
      if (in_poll && (poll_cnt_reg != 24'hFF_FFFF)) poll_cnt_reg <= poll_cnt_reg + 24'd1;
    end
  end

  // Pack register: one byte lane per generate instance, loaded when the
  // returning byte's index selects that lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        lane_reg <= '0;
      else if (lane_we && (idx_reg[1:0] == 2'(gi)))
        lane_reg <= sd_icb_rsp_rdata[7:0];
    end
    assign pack_word[gi*8 +: 8] = lane_reg;
  end

  always_comb begin
    state_next        = state_reg;
    strobe            = '0;
    sector_init       = 1'b0;
    idx_inc           = 1'b0;
    lane_we           = 1'b0;
    seen_set          = 1'b0;
    sd_icb_cmd_valid  = 1'b0;
    sd_icb_cmd_read   = 1'b1;
    sd_icb_cmd_addr   = SDRD_BASE;
    sd_icb_rsp_ready  = 1'b0;
    mem_icb_cmd_valid = 1'b0;
    mem_icb_rsp_ready = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start_pulse) begin
          if (count != 16'd0) begin
            strobe.run = 1'b1;
            state_next = ST_SD_WR;
          end else begin
            strobe.done = 1'b1;
          end
        end
      end

      // sdrd sends no response to writes; the handshake completes it
      ST_SD_WR: begin
        sd_icb_cmd_valid = 1'b1;
        sd_icb_cmd_read  = 1'b0;
        if (sd_icb_cmd_ready) begin
          sector_init = 1'b1;
          state_next  = ST_POLL_CMD;
        end
      end

      ST_POLL_CMD: begin
        sd_icb_cmd_valid = 1'b1;
        if (sd_icb_cmd_ready) state_next = ST_POLL_RSP;
      end

      // Completion needs a busy->idle transition: an idle status before
      // busy was ever seen may be stale (e.g. previous access, or sdrd
      // still busy from a run abandoned by reset).
      ST_POLL_RSP: begin
        sd_icb_rsp_ready = 1'b1;
        if (sd_icb_rsp_valid) begin
          if (sd_busy) seen_set = 1'b1;
          if (!sd_busy && seen_busy_reg) begin
            state_next = ST_RD_CMD;
          end else if (poll_cnt_reg >= POLL_TIMEOUT) begin
            strobe.err_timeout = 1'b1;
            state_next         = ST_IDLE;
          end else begin
            state_next = ST_POLL_CMD;
          end
        end
      end

      ST_RD_CMD: begin
        sd_icb_cmd_valid = 1'b1;
        sd_icb_cmd_addr  = sd_byte_addr(SDRD_BASE, idx_reg);
        if (sd_icb_cmd_ready) state_next = ST_RD_RSP;
      end

      ST_RD_RSP: begin
        sd_icb_rsp_ready = 1'b1;
        if (sd_icb_rsp_valid) begin
          lane_we = 1'b1;
          if (idx_reg[1:0] == 2'd3) begin
            state_next = ST_MW_CMD;
          end else begin
            idx_inc    = 1'b1;
            state_next = ST_RD_CMD;
          end
        end
      end

      ST_MW_CMD: begin
        mem_icb_cmd_valid = 1'b1;
        if (mem_icb_cmd_ready) state_next = ST_MW_RSP;
      end

      ST_MW_RSP: begin
        mem_icb_rsp_ready = 1'b1;
        if (mem_icb_rsp_valid) begin
          if (mem_icb_rsp_err) begin
            strobe.err_bus = 1'b1;
            state_next     = ST_IDLE;
          end else if (idx_reg == LAST_BYTE) begin
            state_next = ST_NEXT;
          end else begin
            idx_inc    = 1'b1;
            state_next = ST_RD_CMD;
          end
        end
      end

      ST_NEXT: begin
        strobe.advance = 1'b1;
        if (count == 16'd1) begin
          strobe.done = 1'b1;
          state_next  = ST_IDLE;
        end else begin
          state_next = ST_SD_WR;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign sd_icb_cmd_wdata  = sector;
  assign sd_icb_cmd_wmask  = 4'hF;

  // Word j of the sector lands at DST + 4*j, j = idx >> 2
  assign mem_icb_cmd_addr  = dst + {23'd0, idx_reg[8:2], 2'b00};
  assign mem_icb_cmd_wdata = pack_word;
  assign mem_icb_cmd_read  = 1'b0;
  assign mem_icb_cmd_wmask = 4'hF;

  assign irq = done | err_timeout | err_bus;

endmodule

// File: tb/tb_sdrd_dma.sv
// tb_sdrd_dma: scoreboard bench for sdrd_dma. Stimulus pushes expected sd
// sector writes and memory writes into queues; monitors pop and compare
// on every command handshake. Includes an sdrd model (busy for busy_len
// cycles after each sector write, byte k reads as k[7:0]) and a memory
// model that can flag an error on one address.
module tb_sdrd_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_icb_cmd_valid = 1'b0;
  logic        cfg_icb_cmd_ready;
  logic        cfg_icb_cmd_read = 1'b0;
  logic [31:0] cfg_icb_cmd_addr = '0;
  logic [31:0] cfg_icb_cmd_wdata = '0;
  logic [3:0]  cfg_icb_cmd_wmask = 4'hF;
  logic        cfg_icb_rsp_valid;
  logic        cfg_icb_rsp_ready = 1'b1;
  logic        cfg_icb_rsp_err;
  logic [31:0] cfg_icb_rsp_rdata;
  logic        sd_icb_cmd_valid;
  logic        sd_icb_cmd_ready = 1'b1;
  logic [31:0] sd_icb_cmd_addr;
  logic        sd_icb_cmd_read;
  logic [31:0] sd_icb_cmd_wdata;
  logic [3:0]  sd_icb_cmd_wmask;
  logic        sd_icb_rsp_valid;
  logic        sd_icb_rsp_ready;
  logic [31:0] sd_icb_rsp_rdata;
  logic        mem_icb_cmd_valid;
  logic        mem_icb_cmd_ready = 1'b1;
  logic [31:0] mem_icb_cmd_addr;
  logic        mem_icb_cmd_read;
  logic [31:0] mem_icb_cmd_wdata;
  logic [3:0]  mem_icb_cmd_wmask;
  logic        mem_icb_rsp_valid;
  logic        mem_icb_rsp_ready;
  logic        mem_icb_rsp_err;
  logic        irq;

  always #5 clk = ~clk;

  sdrd_dma #(.POLL_TIMEOUT(24'd1000), .SDRD_BASE(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_icb_cmd_valid(cfg_icb_cmd_valid), .cfg_icb_cmd_ready(cfg_icb_cmd_ready),
    .cfg_icb_cmd_read(cfg_icb_cmd_read), .cfg_icb_cmd_addr(cfg_icb_cmd_addr),
    .cfg_icb_cmd_wdata(cfg_icb_cmd_wdata), .cfg_icb_cmd_wmask(cfg_icb_cmd_wmask),
    .cfg_icb_rsp_valid(cfg_icb_rsp_valid), .cfg_icb_rsp_ready(cfg_icb_rsp_ready),
    .cfg_icb_rsp_err(cfg_icb_rsp_err), .cfg_icb_rsp_rdata(cfg_icb_rsp_rdata),
    .sd_icb_cmd_valid(sd_icb_cmd_valid), .sd_icb_cmd_ready(sd_icb_cmd_ready),
    .sd_icb_cmd_addr(sd_icb_cmd_addr), .sd_icb_cmd_read(sd_icb_cmd_read),
    .sd_icb_cmd_wdata(sd_icb_cmd_wdata), .sd_icb_cmd_wmask(sd_icb_cmd_wmask),
    .sd_icb_rsp_valid(sd_icb_rsp_valid), .sd_icb_rsp_ready(sd_icb_rsp_ready),
    .sd_icb_rsp_rdata(sd_icb_rsp_rdata),
    .mem_icb_cmd_valid(mem_icb_cmd_valid), .mem_icb_cmd_ready(mem_icb_cmd_ready),
    .mem_icb_cmd_addr(mem_icb_cmd_addr), .mem_icb_cmd_read(mem_icb_cmd_read),
    .mem_icb_cmd_wdata(mem_icb_cmd_wdata), .mem_icb_cmd_wmask(mem_icb_cmd_wmask),
    .mem_icb_rsp_valid(mem_icb_rsp_valid), .mem_icb_rsp_ready(mem_icb_rsp_ready),
    .mem_icb_rsp_err(mem_icb_rsp_err),
    .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } mem_exp_t;

  mem_exp_t    exp_mem[$];
  logic [31:0] exp_sd[$];
  int          mem_seen = 0;
  int          sd_wr_seen = 0;

  // ---------------- sdrd model ----------------
  int          busy_len = 50;
  int          busy_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_icb_rsp_valid <= 1'b0;
      sd_icb_rsp_rdata <= '0;
    end else begin
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      if (sd_icb_rsp_valid && sd_icb_rsp_ready) sd_icb_rsp_valid <= 1'b0;
      if (sd_icb_cmd_valid && sd_icb_cmd_ready) begin
        if (!sd_icb_cmd_read) begin
          busy_cnt <= busy_len;
        end else begin
          sd_icb_rsp_valid <= 1'b1;
          sd_icb_rsp_rdata <= {7'd0, (busy_cnt > 0), 16'd0, sd_icb_cmd_addr[9:2]};
        end
      end
    end
  end

  // ---------------- memory model ----------------
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_icb_rsp_valid <= 1'b0;
      mem_icb_rsp_err   <= 1'b0;
    end else begin
      if (mem_icb_rsp_valid && mem_icb_rsp_ready) mem_icb_rsp_valid <= 1'b0;
      if (mem_icb_cmd_valid && mem_icb_cmd_ready) begin
        mem_icb_rsp_valid <= 1'b1;
        mem_icb_rsp_err   <= (mem_icb_cmd_addr == err_addr);
      end
    end
  end

  // ---------------- monitors (sampled on the falling edge) ----------------
  always @(negedge clk) begin
    if (rst_n && sd_icb_cmd_valid && sd_icb_cmd_ready && !sd_icb_cmd_read) begin
      sd_wr_seen++;
      checks++;
      $display("sd_wr   addr=%h wdata=%h", sd_icb_cmd_addr, sd_icb_cmd_wdata);
      if (exp_sd.size() == 0) begin
        errors++;
        $display("FAIL sd_wr_unexpected: got wdata=%h, required no sd write", sd_icb_cmd_wdata);
      end else begin
        logic [31:0] e;
        e = exp_sd.pop_front();
        if (sd_icb_cmd_wdata !== e || sd_icb_cmd_addr !== 32'h0) begin
          errors++;
          $display("FAIL sd_wr: got addr=%h wdata=%h, required addr=00000000 wdata=%h",
                   sd_icb_cmd_addr, sd_icb_cmd_wdata, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mem_icb_cmd_valid && mem_icb_cmd_ready) begin
      mem_seen++;
      checks++;
      $display("mem_wr  addr=%h wdata=%h", mem_icb_cmd_addr, mem_icb_cmd_wdata);
      if (exp_mem.size() == 0) begin
        errors++;
        $display("FAIL mem_wr_unexpected: got addr=%h wdata=%h, required no mem write",
                 mem_icb_cmd_addr, mem_icb_cmd_wdata);
      end else begin
        mem_exp_t e;
        e = exp_mem.pop_front();
        if (mem_icb_cmd_addr !== e.addr || mem_icb_cmd_wdata !== e.data ||
            mem_icb_cmd_read !== 1'b0 || mem_icb_cmd_wmask !== 4'hF) begin
          errors++;
          $display("FAIL mem_wr: got addr=%h wdata=%h, required addr=%h wdata=%h",
                   mem_icb_cmd_addr, mem_icb_cmd_wdata, e.addr, e.data);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] sector_word(input int j);
    logic [7:0] b0;
    b0 = 8'(4 * j);
    return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
  endfunction

  task automatic push_sector(input logic [31:0] sec, input logic [31:0] dst, input int nwords);
    exp_sd.push_back(sec);
    for (int j = 0; j < nwords; j++) begin
      mem_exp_t e;
      e.addr = dst + 32'(4 * j);
      e.data = sector_word(j);
      exp_mem.push_back(e);
    end
  endtask

  task automatic cfg_access(input logic rd, input logic [1:0] idx, input logic [31:0] wd,
                            output logic [31:0] rdata);
    int guard;
    guard = 0;
    @(negedge clk);
    cfg_icb_cmd_valid = 1'b1;
    cfg_icb_cmd_read  = rd;
    cfg_icb_cmd_addr  = {28'd0, idx, 2'b00};
    cfg_icb_cmd_wdata = wd;
    while (!cfg_icb_cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    cfg_icb_cmd_valid = 1'b0;
    rdata = cfg_icb_rsp_rdata;
    if (!cfg_icb_rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL cfg_rsp_valid: got 0, required 1 (idx %0d)", idx);
    end
    $display("cfg     %s idx=%0d wdata=%h rdata=%h", rd ? "rd" : "wr", idx, wd, rdata);
  endtask

  task automatic cfg_wr(input logic [1:0] idx, input logic [31:0] wd);
    logic [31:0] dummy;
    cfg_access(1'b0, idx, wd, dummy);
  endtask

  task automatic cfg_check(input string name, input logic [1:0] idx, input logic [31:0] exp);
    logic [31:0] r;
    cfg_access(1'b1, idx, 32'd0, r);
    check(name, r, exp);
  endtask

  task automatic wait_irq(input string name, input int limit, output int cycles);
    cycles = 0;
    while (!irq && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (!irq) begin
      errors++;
      $display("FAIL %s: irq still 0 after %0d cycles, required 1", name, limit);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("reset_sd_valid", {31'd0, sd_icb_cmd_valid}, 32'd0);
    check("reset_mem_valid", {31'd0, mem_icb_cmd_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_irq", {31'd0, irq}, 32'd0);
    cfg_check("reset_stat", 2'd3, 32'd0);
    cfg_check("reset_sector", 2'd0, 32'd0);

    // ---- single sector ----
    cfg_wr(2'd0, 32'd5);
    cfg_wr(2'd1, 32'h0000_2003);       // low bits forced to zero
    cfg_check("dst_align", 2'd1, 32'h0000_2000);
    cfg_wr(2'd2, 32'hABCD_0001);       // only 16 bits kept
    cfg_check("count_width", 2'd2, 32'd1);
    push_sector(32'd5, 32'h2000, 128);
    cfg_wr(2'd3, 32'd1);
    wait_irq("one_sector_irq", 3000, cyc);
    @(negedge clk);
    cfg_check("one_sector_stat", 2'd3, 32'h2);
    cfg_check("one_sector_sector", 2'd0, 32'd6);
    cfg_check("one_sector_dst", 2'd1, 32'h2200);
    cfg_check("one_sector_count", 2'd2, 32'd0);
    check("one_sector_irq_level", {31'd0, irq}, 32'd1);
    check("one_sector_mem_left", 32'(exp_mem.size()), 32'd0);

    // ---- three sectors ----
    cfg_wr(2'd3, 32'd2);
    check("clr_irq", {31'd0, irq}, 32'd0);
    cfg_wr(2'd0, 32'd5);
    cfg_wr(2'd1, 32'h2000);
    cfg_wr(2'd2, 32'd3);
    push_sector(32'd5, 32'h2000, 128);
    push_sector(32'd6, 32'h2200, 128);
    push_sector(32'd7, 32'h2400, 128);
    base = mem_seen;
    cfg_wr(2'd3, 32'd1);
    wait_irq("three_sector_irq", 8000, cyc);
    @(negedge clk);
    cfg_check("three_sector_stat", 2'd3, 32'h2);
    check("three_sector_mem_count", 32'(mem_seen - base), 32'd384);
    check("three_sector_sd_left", 32'(exp_sd.size()), 32'd0);
    cfg_check("three_sector_sector", 2'd0, 32'd8);

    // ---- START with COUNT = 0 ----
    cfg_wr(2'd3, 32'd2);
    base = mem_seen + sd_wr_seen;
    cfg_wr(2'd3, 32'd1);
    check("count0_irq_next_cycle", {31'd0, irq}, 32'd1);
    repeat (20) @(negedge clk);
    cfg_check("count0_stat", 2'd3, 32'h2);
    check("count0_no_traffic", 32'(mem_seen + sd_wr_seen - base), 32'd0);

    // ---- poll timeout (sdrd never busy), CLR+START in one write ----
    busy_len = 0;
    cfg_wr(2'd0, 32'd9);
    cfg_wr(2'd1, 32'h4000);
    cfg_wr(2'd2, 32'd1);
    exp_sd.push_back(32'd9);
    cfg_wr(2'd3, 32'd3);
    cfg_check("clr_start_stat", 2'd3, 32'h1);
    wait_irq("timeout_irq", 1100, cyc);
    @(negedge clk);
    cfg_check("timeout_stat", 2'd3, 32'h4);
    check("timeout_sd_left", 32'(exp_sd.size()), 32'd0);

    // ---- bus error on the 10th word ----
    busy_len = 5;
    err_addr = 32'h5024;
    cfg_wr(2'd0, 32'd1);
    cfg_wr(2'd1, 32'h5000);
    cfg_wr(2'd2, 32'd2);
    push_sector(32'd1, 32'h5000, 10);
    cfg_wr(2'd3, 32'd3);
    wait_irq("bus_err_irq", 2000, cyc);
    repeat (50) @(negedge clk);
    cfg_check("bus_err_stat", 2'd3, 32'h8);
    cfg_check("bus_err_count", 2'd2, 32'd2);
    check("bus_err_mem_left", 32'(exp_mem.size()), 32'd0);
    cfg_wr(2'd3, 32'd2);
    cfg_check("bus_err_clr_stat", 2'd3, 32'h0);
    check("bus_err_clr_irq", {31'd0, irq}, 32'd0);
    err_addr = 32'hFFFF_FFFF;

    // ---- writes ignored while busy, then reset mid-RD ----
    busy_len = 50;
    cfg_wr(2'd0, 32'd20);
    cfg_wr(2'd1, 32'h3000);
    cfg_wr(2'd2, 32'd1);
    push_sector(32'd20, 32'h3000, 128);
    base = mem_seen;
    cfg_wr(2'd3, 32'd1);
    repeat (20) @(negedge clk);
    cfg_wr(2'd0, 32'd99);
    cfg_wr(2'd3, 32'd1);
    cfg_check("busy_sector_kept", 2'd0, 32'd20);
    cfg_check("busy_stat", 2'd3, 32'h1);
    cyc = 0;
    while (mem_seen - base < 5 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_rd_words", 32'(mem_seen - base >= 5), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_sd_valid", {31'd0, sd_icb_cmd_valid}, 32'd0);
    check("rst_mem_valid", {31'd0, mem_icb_cmd_valid}, 32'd0);
    check("rst_cfg_rsp_valid", {31'd0, cfg_icb_rsp_valid}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_mem.delete();
    exp_sd.delete();
    cfg_check("rst_stat", 2'd3, 32'h0);
    cfg_check("rst_sector", 2'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
